alu_logic_stage: RTL and testbench
==================================

# alu_logic_stage

Registered bitwise-logic stage of the 16-bit ALU datapath. It accepts operation requests (opcode plus A/B operands) over a valid/ready handshake and evaluates AND/OR/XOR/NOR through a combinational bitwise unit. Results and flags are buffered in a small output FIFO so the downstream writeback/display stage can stall without losing results. It sits between the operand source (testbench driver or register-read stage) and ALU result writeback.

## Interface
- WIDTH, 16, operand/result width in bits
- DEPTH, 2, output FIFO entries; power of two, 2..8
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request this cycle
- in_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  head FIFO entry valid
- out_ready  in  1  downstream accepts head entry
- out_result  out  WIDTH  head result
- out_op  out  2  opcode that produced head result
- out_zero  out  1  head result == 0
- out_neg  out  1  head result MSB
- fill  out  $clog2(DEPTH+1)  occupied entries
- op_count  out  16  number of accepted requests, wraps modulo 2^16

## Operation
- Accept: in_valid && in_ready. Result = op(in_a, in_b), bitwise per index; zero/neg computed from that result; {result, op, zero, neg} written at write pointer.
- in_ready = (fill < DEPTH). Purely a function of registered fill; no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- Pop: out_valid && out_ready advances read pointer.
- Simultaneous push and pop (fill between 1 and DEPTH-1): fill unchanged; both pointers advance.
- Push with fill 0: entry is visible at the output the next cycle, with no bypass.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- out_valid = (fill != 0). While out_valid = 0, out_result, out_op, out_zero and out_neg are driven 0.
- Head outputs hold stable while out_valid && !out_ready.
- op_count increments on every accept and wraps from 0xFFFF to 0x0000.
- Reset (async, any time, including mid-stream): fill = 0, pointers = 0, op_count = 0, out_valid = 0, all out_* data = 0, in_ready = 1 at the first clk after release. Pending entries are discarded.

## Timing
- Latency: accept at edge N means out_valid = 1 with that result after edge N (cycle N+1).
- Throughput: 1 request/cycle while downstream drains every cycle.
- in_ready and out_valid are registered-state decodes. Head data is a mux of storage by the read pointer.
- Upstream must hold in_op/in_a/in_b stable while in_valid && !in_ready. Downstream may drop out_ready at any cycle.

## Structure
- Shared ALU package: opcode constants (OP_AND = 2'b00, OP_OR, OP_XOR, OP_NOR), default WIDTH = 16, and the FIFO entry record {result, op, zero, neg}.
- Sub-module bitwise_unit (combinational, WIDTH-parameterised, opcode select). It produces per-bit results and is reusable by other ALU stages.
- The top level contains the FIFO storage, pointers, fill counter, op_count, and handshake logic.

## Test plan
- NOR: in_a = 0xFFFE, in_b = 0xFFDE, op = 11, out_ready = 1 -> one cycle later out_result = 0x0001, zero = 0, neg = 0, op_count = 1.
- Ops sweep: a = 0xF0F0, b = 0xFF00 -> AND 0xF000 (neg = 1), OR 0xFFF0, XOR 0x0FF0, NOR 0x000F. Delivered in order at 1/cycle.
- Backpressure: out_ready = 0, push 3 requests with DEPTH = 2 -> after 2 accepts, in_ready = 0, fill = 2. The third request is held, head is stable, and release drains in order.
- Simultaneous push/pop at fill = 1 -> fill stays 1 and order is preserved across pointer wrap over 10 transactions.
- Zero flag: AND of 0x5555 and 0xAAAA -> result 0x0000, zero = 1.
- Reset mid-stream with fill = 2 and op_count = 5 -> immediately out_valid = 0 and data = 0; after release, fill = 0, op_count = 0, in_ready = 1. op_count wrap: 65536 accepts from 0 -> 0x0000.

Source files
------------

// File: rtl/alu_logic_stage_pkg.sv
// Shared ALU definitions: opcodes, default datapath width and the result record
// carried by ALU stages toward writeback.
package alu_logic_stage_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    alu_op_e              op;
    logic                 zero;
    logic                 neg;
  } alu_entry_t;

endpackage

// File: rtl/alu_logic_stage_if.sv
// Request/response bundle of the logic stage: upstream valid/ready request side,
// downstream valid/ready result side, plus occupancy and accept-count status.
interface alu_logic_stage_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);
  localparam int FW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic [FW-1:0]    fill;
  logic [15:0]      op_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, fill, op_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_neg, fill, op_count
  );
endinterface

// File: rtl/alu_logic_stage_bitwise_unit.sv
// Combinational bitwise AND/OR/XOR/NOR, one independent lane per bit so it can be
// dropped into any ALU stage at any width.
module bitwise_unit
  import alu_logic_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = (op == OP_AND) ?   a[i] & b[i]  :
                  (op == OP_OR)  ?   a[i] | b[i]  :
                  (op == OP_XOR) ?   a[i] ^ b[i]  :
                                   ~(a[i] | b[i]);
  end
endmodule

// File: rtl/alu_logic_stage.sv
// Registered logic stage: evaluates a bitwise op per accepted request and queues
// {result, op, zero, neg} in a small FIFO so writeback can stall.
module alu_logic_stage
  import alu_logic_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  alu_logic_stage_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_op_e          op;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic   [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic   [FW-1:0]    fill_q, fill_d;
  logic   [15:0]      op_count_q, op_count_d;

  logic [WIDTH-1:0] alu_y;
  logic             push, pop;
  entry_t           new_entry, head;

  bitwise_unit #(.WIDTH(WIDTH)) u_bitwise (
    .op (alu_op_e'(bus.in_op)),
    .a  (bus.in_a),
    .b  (bus.in_b),
    .y  (alu_y)
  );

  // Ready depends only on registered fill, so a pop never opens a slot same-cycle.
  assign bus.in_ready  = (fill_q < FW'(DEPTH));
  assign bus.out_valid = (fill_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.result = alu_y;
    new_entry.op     = alu_op_e'(bus.in_op);
    new_entry.zero   = (alu_y == '0);
    new_entry.neg    = alu_y[WIDTH-1];
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fill_d     = fill_q + FW'(push) - FW'(pop);
    op_count_d = op_count_q;
    if (push) begin
      mem_d[wptr_q] = new_entry;
      wptr_d        = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      op_count_d    = op_count_q + 16'd1;
    end
    if (pop)
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      op_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      op_count_q <= op_count_d;
    end
  end

  // Head fields are gated so an empty FIFO presents all-zero data.
  always_comb begin
    head = '0;
    if (bus.out_valid) head = mem_q[rptr_q];
  end

  assign bus.out_result = head.result;
  assign bus.out_op     = head.op;
  assign bus.out_zero   = head.zero;
  assign bus.out_neg    = head.neg;
  assign bus.fill       = fill_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_logic_stage.sv
// Randomized and directed checks of alu_logic_stage against a queue-based model.
module tb_alu_logic_stage;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  alu_logic_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  alu_logic_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic [1:0]  op;
  } exp_t;

  exp_t        q[$];
  logic [15:0] cnt;
  int          n_vec, n_err;
  bit          chk_en;

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] r;
    logic [1:0]  op;
    r  = 16'h0;
    op = 2'd0;
    if (q.size() != 0) begin
      r  = q[0].r;
      op = q[0].op;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
    chk("fill",      32'(bus.fill),      32'(q.size()));
    chk("op_count",  32'(bus.op_count),  32'(cnt));
    chk("result",    32'(bus.out_result), 32'(r));
    chk("op",        32'(bus.out_op),     32'(op));
    chk("zero",      32'(bus.out_zero),   32'((q.size() != 0) && (r == 16'h0)));
    chk("neg",       32'(bus.out_neg),    32'(r[15]));
  endtask

  task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy, output logic acc);
    logic pp;
    @(negedge clk);
    if (chk_en) check_model();
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    acc = v && (q.size() < DEPTH);
    pp  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back('{r: ref_op(op, a, b), op: op});
      cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.out_result), 32'd0);
    chk("rst_fill",      32'(bus.fill), 32'd0);
    chk("rst_op_count",  32'(bus.op_count), 32'd0);
    bus.in_valid = 0;
    q.delete();
    cnt = 16'h0;
    @(negedge clk);
    rst = 0;
  endtask

  logic acc;
  logic [15:0] ra, rb;
  logic [1:0]  rop;
  logic        rv;

  initial begin
    n_vec = 0; n_err = 0; chk_en = 1; cnt = 16'h0;
    bus.in_valid = 0; bus.in_op = 2'd0; bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 0;
    #12 rst = 0;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_valid",    32'(bus.out_valid), 32'd0);

    // NOR example
    cycle(1, 2'b11, 16'hFFFE, 16'hFFDE, 1, acc);
    #1;
    chk("nor_result", 32'(bus.out_result), 32'h0001);
    chk("nor_zero",   32'(bus.out_zero), 32'd0);
    chk("nor_neg",    32'(bus.out_neg), 32'd0);
    chk("nor_count",  32'(bus.op_count), 32'd1);

    // Ops sweep at one per cycle
    cycle(1, 2'b00, 16'hF0F0, 16'hFF00, 1, acc); #1;
    chk("and_result", 32'(bus.out_result), 32'hF000);
    chk("and_neg",    32'(bus.out_neg), 32'd1);
    cycle(1, 2'b01, 16'hF0F0, 16'hFF00, 1, acc); #1;
    chk("or_result",  32'(bus.out_result), 32'hFFF0);
    cycle(1, 2'b10, 16'hF0F0, 16'hFF00, 1, acc); #1;
    chk("xor_result", 32'(bus.out_result), 32'h0FF0);
    cycle(1, 2'b11, 16'hF0F0, 16'hFF00, 1, acc); #1;
    chk("nor2_result", 32'(bus.out_result), 32'h000F);
    cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);

    // Backpressure with a held third request
    cycle(1, 2'b00, 16'h1234, 16'h00FF, 0, acc);
    cycle(1, 2'b01, 16'h1200, 16'h0034, 0, acc);
    cycle(1, 2'b10, 16'hAAAA, 16'h0F0F, 0, acc); #1;
    chk("bp_third_held", 32'(acc), 32'd0);
    chk("bp_in_ready",   32'(bus.in_ready), 32'd0);
    chk("bp_fill",       32'(bus.fill), 32'd2);
    chk("bp_head",       32'(bus.out_result), 32'h0034);
    cycle(1, 2'b10, 16'hAAAA, 16'h0F0F, 0, acc); #1;
    chk("bp_head_stable", 32'(bus.out_result), 32'h0034);
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) cycle(1, 2'b10, 16'hAAAA, 16'h0F0F, 1, acc);
    chk("bp_third_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);

    // Zero flag
    cycle(1, 2'b00, 16'h5555, 16'hAAAA, 1, acc); #1;
    chk("zero_result", 32'(bus.out_result), 32'h0000);
    chk("zero_flag",   32'(bus.out_zero), 32'd1);

    // Steady push+pop at fill 1 across pointer wrap
    for (int i = 0; i < 10; i++) begin
      cycle(1, 2'(i), 16'(i * 16'h1111), 16'(16'h0F0F + i), 1, acc); #1;
      chk("pp_fill", 32'(bus.fill), 32'd1);
    end
    cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);

    // Reset mid-stream with fill 2, op_count 5
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 2'b01, 16'(i), 16'h0100, 1, acc);
    cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);
    cycle(1, 2'b10, 16'h00FF, 16'hFF00, 0, acc);
    cycle(1, 2'b11, 16'h0000, 16'h0000, 0, acc); #1;
    chk("pre_rst_fill",  32'(bus.fill), 32'd2);
    chk("pre_rst_count", 32'(bus.op_count), 32'd5);
    do_reset();
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_fill",  32'(bus.fill), 32'd0);

    // Random traffic honouring the hold rule
    rv = 0; ra = 0; rb = 0; rop = 0; acc = 1;
    for (int i = 0; i < 1500; i++) begin
      if (!(rv && !acc)) begin
        rv  = ($urandom_range(0, 3) != 0);
        rop = 2'($urandom_range(0, 3));
        ra  = 16'($urandom);
        rb  = 16'($urandom);
      end
      cycle(rv, rop, ra, rb, ($urandom_range(0, 2) != 0), acc);
    end
    for (int i = 0; i < 4; i++) cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);

    // op_count wrap after 65536 accepts from zero
    do_reset();
    chk_en = 0;
    for (int i = 0; i < 65536; i++) cycle(1, 2'b01, 16'(i), 16'h0, 1, acc);
    chk_en = 1;
    cycle(0, 2'b00, 16'h0, 16'h0, 1, acc); #1;
    chk("wrap_count", 32'(bus.op_count), 32'h0000);
    cycle(0, 2'b00, 16'h0, 16'h0, 1, acc);
    @(negedge clk);
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
